// File: rtl/waveform_readback_if.sv
// AXI4 read-address/read-data channels plus the downstream sample stream of waveform_readback.
// master = the read engine, slave = interconnect / readout side.
interface waveform_readback_if #(
   parameter int AXI_ADDR_WIDTH = 35,
   parameter int AXI_DATA_WIDTH = 128
);
   logic [AXI_ADDR_WIDTH-1:0] axi_ARADDR;
   logic [7:0]                axi_ARLEN;
   logic                      axi_ARVALID;
   logic                      axi_ARREADY;
   logic [AXI_DATA_WIDTH-1:0] axi_RDATA;
   logic [1:0]                axi_RRESP;
   logic                      axi_RLAST;
   logic                      axi_RVALID;
   logic                      axi_RREADY;
   logic [AXI_DATA_WIDTH-1:0] outData;
   logic                      outValid;
   logic                      outReady;
   logic                      outLast;

   modport master (
      output axi_ARADDR, axi_ARLEN, axi_ARVALID,
      input  axi_ARREADY,
      input  axi_RDATA, axi_RRESP, axi_RLAST, axi_RVALID,
      output axi_RREADY,
      output outData, outValid, outLast,
      input  outReady
   );

   modport slave (
      input  axi_ARADDR, axi_ARLEN, axi_ARVALID,
      output axi_ARREADY,
      output axi_RDATA, axi_RRESP, axi_RLAST, axi_RVALID,
      input  axi_RREADY,
      input  outData, outValid, outLast,
      output outReady
   );
endinterface

// File: rtl/waveform_readback.sv
// AXI4 INCR read master replaying a stored acquisition as a sample stream; define WAVEFORM_READBACK_4K_SPLIT_EN to split bursts at 4 KiB.
// Latency: start->ARVALID 1 cycle, R beat->outValid 1 cycle, RLAST->next ARVALID 1 cycle; one burst outstanding.
// Backpressure: RREADY only while the one-entry output register is empty or draining.
module waveform_readback #(
   parameter int AXI_ADDR_WIDTH  = 35,
   parameter int AXI_DATA_WIDTH  = 128,
   parameter int MAX_BURST_BEATS = 16,
   parameter int COUNT_WIDTH     = 24
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [AXI_ADDR_WIDTH-1:0] startAddress,
   input  logic [COUNT_WIDTH-1:0]    beatCount,
   output logic                      busy,
   output logic                      done,
   output logic                      rrespError,
   waveform_readback_if.master       bus
);
   localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;
   localparam int ADDR_LSB   = $clog2(BEAT_BYTES);
   localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_MASK = AXI_ADDR_WIDTH'(BEAT_BYTES - 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, FLUSH} state_t;
   state_t state_q, state_d;

   logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_src;
   logic [7:0]                arlen_q;
   logic [COUNT_WIDTH-1:0]    rem_q, rem_src;
   logic [8:0]                cap, len_n, ar_beats;
   logic [AXI_DATA_WIDTH-1:0] out_data_q;
   logic                      out_valid_q, out_last_q;
   logic                      busy_q, done_q, rresp_err_q;
   logic                      arvalid, rready, ar_hs, r_hs;
   logic                      start_go, zero_go, reload, finish;

   // Next burst is sized from the start request in IDLE, otherwise from the running address/remaining.
   assign ar_addr_src = (state_q == IDLE) ? (startAddress & ~BEAT_MASK) : ar_addr_q;
   assign rem_src     = (state_q == IDLE) ? beatCount : rem_q;

`ifdef WAVEFORM_READBACK_4K_SPLIT_EN
   logic [12:0] to_bnd_beats;
   assign to_bnd_beats = (13'd4096 - {1'b0, ar_addr_src[11:0]}) >> ADDR_LSB;
   assign cap = (to_bnd_beats < 13'(MAX_BURST_BEATS)) ? 9'(to_bnd_beats) : 9'(MAX_BURST_BEATS);
`else
   assign cap = 9'(MAX_BURST_BEATS);
`endif

   assign len_n    = (rem_src < COUNT_WIDTH'(cap)) ? 9'(rem_src) : cap;
   assign ar_beats = {1'b0, arlen_q} + 9'd1;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      arvalid  = 1'b0;
      rready   = 1'b0;
      start_go = 1'b0;
      zero_go  = 1'b0;
      reload   = 1'b0;
      finish   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (beatCount != '0) begin
                  start_go = 1'b1;
                  state_d  = ADDR;
               end else begin
                  zero_go = 1'b1;
               end
            end
         end
         ADDR: begin
            arvalid = 1'b1;
            if (bus.axi_ARREADY) state_d = DATA;
         end
         DATA: begin
            rready = !out_valid_q || bus.outReady;
            if (rready && bus.axi_RVALID && bus.axi_RLAST) begin
               if (rem_q != '0) begin
                  reload  = 1'b1;
                  state_d = ADDR;
               end else begin
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (out_valid_q && bus.outReady && out_last_q) begin
               finish  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ar_hs = arvalid && bus.axi_ARREADY;
   assign r_hs  = rready && bus.axi_RVALID;

   always_ff @(posedge clk) begin
      if (reset) begin
         ar_addr_q   <= '0;
         arlen_q     <= '0;
         rem_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rresp_err_q <= 1'b0;
      end else begin
         if (start_go || reload) begin
            ar_addr_q <= ar_addr_src;
            arlen_q   <= 8'(len_n - 9'd1);
         end
         if (start_go) begin
            rem_q  <= beatCount;
            busy_q <= 1'b1;
         end
         // ARADDR advances past the accepted burst; it is only observed while ARVALID is high.
         if (ar_hs) begin
            ar_addr_q <= ar_addr_q + (AXI_ADDR_WIDTH'(ar_beats) << ADDR_LSB);
            rem_q     <= rem_q - COUNT_WIDTH'(ar_beats);
         end
         if (r_hs) begin
            out_data_q  <= bus.axi_RDATA;
            out_valid_q <= 1'b1;
            out_last_q  <= bus.axi_RLAST && (rem_q == '0);
         end else if (out_valid_q && bus.outReady) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end
         if (state_q == IDLE && start)             rresp_err_q <= 1'b0;
         else if (r_hs && bus.axi_RRESP != 2'b00)  rresp_err_q <= 1'b1;
         if (finish) busy_q <= 1'b0;
         done_q <= finish || zero_go;
      end
   end

   assign bus.axi_ARADDR  = ar_addr_q;
   assign bus.axi_ARLEN   = arlen_q;
   assign bus.axi_ARVALID = arvalid;
   assign bus.axi_RREADY  = rready;
   assign bus.outData     = out_data_q;
   assign bus.outValid    = out_valid_q;
   assign bus.outLast     = out_last_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign rrespError      = rresp_err_q;
endmodule
